spram32_arb: RTL
================

// Module: spram32_arb
// PURPOSE
//  Round-robin arbiter sharing one 32K x 32 single-port SRAM (spram32_32k behind iBus32) among NREQ requesters.
//  Sits between the eForth core, DMA/loader and debug ports and the single memory macro.
//  Grants one access per cycle, steers byte-masked writes and returns 1-cycle-latency read data to the issuer.
//  An optional lock lets a requester hold the memory for bursts (e.g. block moves).
// PARAMETERS
//  NREQ  2   number of requesters (2..4)
//  ASZ   15  word address width (32K words)
//  DSZ   32  data width
// PORTS
//  clk        in   1          system clock, all state on posedge
//  rst        in   1          asynchronous, active-high reset
//  req        in   NREQ       per-requester access request, held until gnt
//  lock       in   NREQ       requester keeps grant while req&lock stay high
//  we         in   NREQ       1 = write, 0 = read
//  ai         in   NREQ*ASZ   per-requester word address
//  vi         in   NREQ*DSZ   per-requester write data
//  bmsk       in   NREQ*4     per-requester byte enables (bit0 = byte 0)
//  gnt        out  NREQ       one-hot: access accepted this cycle
//  rvld       out  NREQ       one-hot: read data valid on vo for that requester
//  vo         out  DSZ        read data (shared, qualify with rvld)
//  mem_ai     out  ASZ        to SRAM address
//  mem_we     out  1          to SRAM write enable
//  mem_vi     out  DSZ        to SRAM write data
//  mem_bmsk   out  4          to SRAM byte mask
//  mem_vo     in   DSZ        from SRAM, registered read data, valid 1 cycle after address
// BEHAVIOUR
//  - Reset: gnt=0, rvld=0, mem_we=0, mem_ai/mem_vi/mem_bmsk=0, last=NREQ-1 (requester 0 wins first), owner=none.
//  - Arbitration is combinational within the cycle: gnt and mem_* derive from req, last, owner.
//  - Owner valid (lock[o] & req[o] held since its last grant): o granted unconditionally; others wait.
//  - Otherwise: first requester with req=1 scanning from last+1 modulo NREQ wins; last<=winner on posedge.
//  - Owner is set on the grant cycle when lock[winner]=1; cleared the first cycle req[o]=0 or lock[o]=0,
//    and the same cycle falls back to round-robin (no idle bubble).
//  - No req: gnt=0, mem_we=0, mem_ai/vi/bmsk hold previous value; last unchanged.
//  - Write: mem_we=1, mem_bmsk=bmsk[w]; complete in the grant cycle, no rvld.
//  - Read: mem_we=0, mem_bmsk=bmsk[w] forwarded; rvld[w]=1 exactly one cycle later, vo=mem_vo.
//  - Back-to-back reads by different requesters pipeline: one result per cycle, in grant order.
//  - bmsk=0 on a write: access granted, memory unchanged (counts as a slot).
//  - Read rvld is registered (rd_pend flag + rd_id); no other latency anywhere.
//  - Address is word-based; out-of-range is impossible (ASZ bits), 'h7fff wraps to none.
//  - Simultaneous lock release and new req from another port: released port is 'last', others rotate.
//  - Reset mid-read: pending rvld dropped, no data delivered; lock ownership cleared.
//  - Requesters must hold req/we/ai/vi/bmsk stable until gnt; changes before gnt are not errors.
// STRUCTURE
//  - spram32_pkg: ASZ, DSZ, BSZ=4 constants; typedefs addr_t, data_t, bmsk_t; function rr_next().
//  - Sub-module rr_pick: NREQ-bit round-robin priority encoder (req, last -> one-hot winner, valid).
//  - Top: owner/lock register, last pointer, rd_pend/rd_id pipeline flop, muxes onto mem_* bus.
// TESTING (drive arbiter into spram32_32k, bmsk=4'b1111 unless noted)
//  1. After reset req=2'b11, both read -> gnt[0] cycle1, gnt[1] cycle2; rvld[0] cycle2, rvld[1] cycle3.
//  2. P0 writes ai=0..14 vi=(1<<i)|(i&3) while P1 idle -> P0 granted every cycle; P1 reads 0..14 back same values.
//  3. P0 lock=1 burst 8 writes to 'h7ff0.. with P1 req=1 continuously -> P1 gnt only after P0 drops lock, no bubble.
//  4. P0 write 'h1234_5678 @'h20 bmsk=4'b0011 over 'hFFFF_FFFF -> P1 read @'h20 returns 'hFFFF_5678.
//  5. Assert rst one cycle after a P1 read grant -> rvld stays 0, gnt=0; next grant goes to requester 0.
//  6. 1000 cycles random req/we both ports -> each req granted within NREQ cycles, scoreboard matches vo.

Source files
------------

// File: rtl/spram32_arb_pkg.sv
// Shared constants, types and helpers for the spram32 round-robin arbiter.
package spram32_arb_pkg;

   localparam int unsigned ASZ = 15;   // word address width (32K words)
   localparam int unsigned DSZ = 32;   // data width
   localparam int unsigned BSZ = 4;    // byte lanes per word
   localparam int unsigned IDW = 2;    // requester index width (up to 4 requesters)

   typedef logic [ASZ-1:0] addr_t;
   typedef logic [DSZ-1:0] data_t;
   typedef logic [BSZ-1:0] bmsk_t;
   typedef logic [IDW-1:0] id_t;

   // Memory-side command payload (write enable is carried separately)
   typedef struct packed {
      addr_t ai;
      data_t vi;
      bmsk_t bmsk;
   } mem_cmd_t;

   // Next requester index, wrapping modulo n
   function automatic id_t rr_next(input id_t cur, input int unsigned n);
      if (32'(cur) + 32'd1 >= n) return '0;
      return cur + id_t'(1);
   endfunction

endpackage

// File: rtl/spram32_arb_if.sv
// Requester-side bus of the spram32 arbiter: per-port request/command in, grant/read data out.
interface spram32_arb_if
   import spram32_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2
);

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] lock;
   logic [NREQ-1:0] we;
   addr_t           ai   [NREQ];
   data_t           vi   [NREQ];
   bmsk_t           bmsk [NREQ];
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] rvld;
   data_t           vo;

   modport master (
      output req, lock, we, ai, vi, bmsk,
      input  gnt, rvld, vo
   );

   modport slave (
      input  req, lock, we, ai, vi, bmsk,
      output gnt, rvld, vo
   );

endinterface

// File: rtl/spram32_arb_rr_pick.sv
// Round-robin priority encoder: first active request after 'last', modulo NREQ.
module spram32_arb_rr_pick
   import spram32_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  id_t             last,
   output id_t             win_id,
   output logic            win_vld
);

   id_t scan;

   // Walk indices last+1, last+2, ... and take the first requester found
   always_comb begin
      win_id  = last;
      win_vld = 1'b0;
      scan    = last;
      for (int k = 0; k < int'(NREQ); k++) begin
         scan = rr_next(scan, NREQ);
         for (int j = 0; j < int'(NREQ); j++) begin
            if (!win_vld && req[j] && (id_t'(j) == scan)) begin
               win_id  = scan;
               win_vld = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spram32_arb.sv
// Round-robin arbiter sharing one single-port 32K x 32 SRAM among NREQ requesters,
// with optional burst lock and a one-cycle read return pipeline.
module spram32_arb
   import spram32_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic          clk,
   input  logic          rst,
   spram32_arb_if.slave  bus,
   output addr_t         mem_ai,
   output logic          mem_we,
   output data_t         mem_vi,
   output bmsk_t         mem_bmsk,
   input  data_t         mem_vo
);

   id_t      last;        // most recently granted requester
   logic     owner_vld;   // a locked requester holds the memory
   id_t      owner_id;
   logic     rd_pend;     // read issued last cycle, data arrives now
   id_t      rd_id;
   mem_cmd_t hold;        // bus value kept on idle cycles

   id_t      pick_id;
   logic     pick_vld;
   logic     owner_act;
   id_t      sel_id;
   logic     sel_vld;
   logic     sel_we;
   logic     sel_lock;
   mem_cmd_t sel_cmd;

   spram32_arb_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req     (bus.req),
      .last    (last),
      .win_id  (pick_id),
      .win_vld (pick_vld)
   );

   // Owner keeps the memory only while its req and lock are both still high
   always_comb begin
      owner_act = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (owner_vld && (id_t'(i) == owner_id) && bus.req[i] && bus.lock[i]) begin
            owner_act = 1'b1;
         end
      end
   end

   assign sel_id  = owner_act ? owner_id : pick_id;
   assign sel_vld = !rst && (owner_act || pick_vld);

   // Steer the winner's command onto the memory bus; idle cycles replay the held value
   always_comb begin
      sel_we   = 1'b0;
      sel_lock = 1'b0;
      sel_cmd  = hold;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (sel_vld && (id_t'(i) == sel_id)) begin
            sel_we       = bus.we[i];
            sel_lock     = bus.lock[i];
            sel_cmd.ai   = bus.ai[i];
            sel_cmd.vi   = bus.vi[i];
            sel_cmd.bmsk = bus.bmsk[i];
         end
      end
   end

   assign mem_ai   = sel_cmd.ai;
   assign mem_vi   = sel_cmd.vi;
   assign mem_bmsk = sel_cmd.bmsk;
   assign mem_we   = sel_we;

   // One-hot grant for this cycle and read-valid for last cycle's read
   always_comb begin
      bus.gnt  = '0;
      bus.rvld = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         bus.gnt[i]  = sel_vld && (id_t'(i) == sel_id);
         bus.rvld[i] = rd_pend && (id_t'(i) == rd_id);
      end
   end

   assign bus.vo = mem_vo;

   // Arbitration state, lock ownership and read-return pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last      <= id_t'(NREQ - 1);
         owner_vld <= 1'b0;
         owner_id  <= '0;
         rd_pend   <= 1'b0;
         rd_id     <= '0;
         hold      <= '0;
      end else begin
         rd_pend   <= sel_vld && !sel_we;
         rd_id     <= sel_id;
         owner_vld <= sel_vld && sel_lock;
         owner_id  <= sel_id;
         if (sel_vld) begin
            last <= sel_id;
            hold <= sel_cmd;
         end
      end
   end

endmodule
